exu_upper_q: RTL
================

Name: exu_upper_q

Overview:
Parametrised U-type execute unit for LUI and AUIPC. It computes the upper-immediate result when the decoder flags an upper instruction at the issue cycle. Instead of driving the shared regfile write port as a tri-state bus, it buffers results in a small FIFO and presents them to the write-back arbiter through a valid/ready handshake. It adds backpressure, flush, x0 suppression and occupancy reporting.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
DEPTH, 2, result FIFO entries; power of two, at least 2.
PC_OFFSET, 8, value subtracted from pc for AUIPC (pipeline PC skew).
ISSUE_CYCLE, 1, cycle_cnt value at which decoder outputs are valid.

Ports:
hclk  input  1  clock; all logic on rising edge.
hrstn  input  1  asynchronous active-low reset.
cycle_cnt  input  4  instruction sub-cycle counter.
dec_upper_en  input  1  decoded instruction is LUI or AUIPC.
dec_lui  input  1  LUI select.
dec_auipc  input  1  AUIPC select.
dec_imm_type_u  input  20  U-type immediate, bits 31:12.
dec_rd  input  5  destination register.
pc  input  XLEN  current PC.
exu_stall  input  1  pipeline stall; blocks issue.
exu_flush  input  1  synchronous flush of all queued results.
wb_valid  output  1  head entry available.
wb_ready  input  1  arbiter accepts head entry this cycle.
wb_waddr  output  5  head rd.
wb_wdata  output  XLEN  head result.
upper_full  output  1  FIFO full; the decoder must hold the instruction.
upper_cnt  output  clog2(DEPTH+1)  occupancy.
upper_ovf  output  1  sticky: an issue was dropped because the FIFO was full.

Behaviour:
- Reset (hrstn low, asynchronous): FIFO emptied and pointers zeroed. wb_valid, wb_waddr, wb_wdata, upper_full, upper_cnt and upper_ovf are all 0.
- Issue condition: dec_upper_en && cycle_cnt==ISSUE_CYCLE && !exu_stall && !exu_flush.
- Result:
  - imm_ext = {dec_imm_type_u,12'b0}, sign-extended from bit 31 to XLEN when XLEN=64.
  - LUI: imm_ext.
  - AUIPC: imm_ext + (pc - PC_OFFSET), modulo 2^XLEN; carries are discarded.
  - Neither select set: 0.
  - If both selects are set, LUI wins.
- dec_rd==0: result discarded. No push, no overflow flag.
- Push: issue && rd!=0 && (!full || pop). Simultaneous push and pop when full is legal; occupancy is unchanged.
- Dropped issue (issue && rd!=0 && full && !pop): no push; upper_ovf is set to 1 and cleared only by reset.
- Pop: wb_valid && wb_ready. The head advances on the next edge.
- Latency: an entry pushed on edge N is visible on wb_valid/wb_waddr/wb_wdata after edge N (next cycle). There is no combinational input-to-wb path.
- wb outputs are stable while wb_valid && !wb_ready. When empty, wb_waddr and wb_wdata are 0.
- Pointers wrap modulo DEPTH. upper_full = (cnt==DEPTH), combinational from registered cnt.
- exu_flush: on the next edge cnt=0 and pointers are reset. A same-cycle issue or pop is ignored; flush has priority.
- Holding cycle_cnt at ISSUE_CYCLE for several cycles issues once per cycle. The decoder owns single-pulse behaviour.

Decomposition:
- Package exu_upper_pkg holds:
  - localparam UIMM_W=20 and UIMM_SH=12;
  - an enum upper_op_e {UP_NONE, UP_LUI, UP_AUIPC};
  - function upper_calc(op, imm, pc, offset) returning XLEN bits.
- One sub-module, exu_upper_fifo (DEPTH x (5+XLEN)), provides push/pop/flush, cnt and full/empty.
- The top level keeps the issue qualification, result computation and overflow flag.

Test Plan:
- LUI, imm=20'h12345, rd=5, cycle_cnt=1 -> next cycle wb_valid=1, waddr=5, wdata=32'h12345000; pop with wb_ready=1 -> cnt=0.
- AUIPC, imm=20'h00001, pc=32'h0000_0108, PC_OFFSET=8 -> wdata=32'h0000_1100. AUIPC with imm=20'hFFFFF and pc=32'h0000_1008 -> wdata=32'h0000_0000 (wrap).
- wb_ready=0 with DEPTH=2: issue rd=1, rd=2 -> upper_full=1, cnt=2. Third issue rd=3 -> dropped, upper_ovf=1, head still waddr=1. Then ready=1 -> rd=1 then rd=2 are delivered in order.
- Full FIFO, issue rd=7 with wb_ready=1 in the same cycle -> push accepted, cnt stays 2, upper_ovf stays 0, order 2 then 7.
- rd=0 LUI, or exu_stall=1, or cycle_cnt=2 -> no push, wb_valid stays 0.
- Two entries queued, exu_flush=1 with a concurrent issue -> next cycle cnt=0, wb_valid=0. Assert hrstn low mid-queue -> all outputs 0 immediately.
- XLEN=64 LUI imm=20'h80000 -> wdata=64'hFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/exu_upper_pkg.sv
// Shared types and the upper-immediate result function for the U-type execute unit.
package exu_upper_pkg;

  localparam int unsigned UIMM_W  = 20;
  localparam int unsigned UIMM_SH = 12;

  typedef enum logic [1:0] {
    UP_NONE,
    UP_LUI,
    UP_AUIPC
  } upper_op_e;

  // Computed at 64 bits; callers truncate to XLEN, which keeps the result modulo 2^XLEN.
  function automatic logic [63:0] upper_calc(input upper_op_e         op,
                                             input logic [UIMM_W-1:0] imm,
                                             input logic [63:0]       pc,
                                             input logic [63:0]       offset);
    logic [63:0] imm_ext;
    logic [63:0] res;
    imm_ext = {{(64 - UIMM_W - UIMM_SH){imm[UIMM_W-1]}}, imm, {UIMM_SH{1'b0}}};
    unique case (op)
      UP_LUI:   res = imm_ext;
      UP_AUIPC: res = imm_ext + (pc - offset);
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exu_upper_fifo.sv
// Result FIFO: DEPTH entries of WIDTH bits, flush has priority over push and pop.
module exu_upper_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             hclk,
  input  logic             hrstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign cnt     = cnt_q;
  assign head    = empty ? '0 : mem_q[rptr_q];
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge hclk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/exu_upper_q.sv
// U-type execute unit (LUI/AUIPC) with a queued valid/ready write-back port.
module exu_upper_q
  import exu_upper_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned PC_OFFSET   = 8,
  parameter int unsigned ISSUE_CYCLE = 1,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              hclk,
  input  logic              hrstn,
  input  logic [3:0]        cycle_cnt,
  input  logic              dec_upper_en,
  input  logic              dec_lui,
  input  logic              dec_auipc,
  input  logic [19:0]       dec_imm_type_u,
  input  logic [4:0]        dec_rd,
  input  logic [XLEN-1:0]   pc,
  input  logic              exu_stall,
  input  logic              exu_flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_waddr,
  output logic [XLEN-1:0]   wb_wdata,
  output logic              upper_full,
  output logic [CNT_W-1:0]  upper_cnt,
  output logic              upper_ovf
);

  localparam int unsigned ENTRY_W = 5 + XLEN;

  upper_op_e          op;
  logic [XLEN-1:0]    result;
  logic               issue;
  logic               rd_nz;
  logic               push;
  logic               pop;
  logic               drop;
  logic               empty;
  logic [ENTRY_W-1:0] head;
  logic               ovf_q;

  assign issue = dec_upper_en && (cycle_cnt == 4'(ISSUE_CYCLE)) && !exu_stall && !exu_flush;
  assign rd_nz = (dec_rd != 5'd0);

  // LUI wins when both selects are set.
  always_comb begin
    op = UP_NONE;
    if (dec_lui)        op = UP_LUI;
    else if (dec_auipc) op = UP_AUIPC;
  end

  assign result = XLEN'(upper_calc(op, dec_imm_type_u, 64'(pc), 64'(PC_OFFSET)));

  assign pop  = wb_valid && wb_ready;
  assign push = issue && rd_nz && (!upper_full || pop);
  assign drop = issue && rd_nz && upper_full && !pop;

  exu_upper_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .hclk  (hclk),
    .hrstn (hrstn),
    .push  (push),
    .wdata ({dec_rd, result}),
    .pop   (pop),
    .flush (exu_flush),
    .head  (head),
    .cnt   (upper_cnt),
    .full  (upper_full),
    .empty (empty)
  );

  assign wb_valid = !empty;
  assign wb_waddr = head[ENTRY_W-1:XLEN];
  assign wb_wdata = head[XLEN-1:0];
  assign upper_ovf = ovf_q;

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

endmodule
